// File: rtl/global_fused_load_scheduler.sv
// Fused-layer tile loader: streams IFM, layer-1 and layer-2 weights from the
// 128-bit global BRAM into the local BRAMs, one word per cycle.
module global_fused_load_scheduler #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16,
  parameter int N_W1   = 16,
  parameter int N_W2   = 4,
  parameter int WE_W   = N_W1 + N_W2 + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ready,
  output logic              done,
  input  logic [ADDR_W-1:0] base_addr_IFM,
  input  logic [CNT_W-1:0]  size_IFM,
  input  logic [ADDR_W-1:0] base_addr_Weight_layer_1,
  input  logic [CNT_W-1:0]  size_Weight_layer_1,
  input  logic [ADDR_W-1:0] base_addr_Weight_layer_2,
  input  logic [CNT_W-1:0]  size_Weight_layer_2,
  output logic [ADDR_W-1:0] rd_addr_global,
  output logic              we_global,
  output logic [ADDR_W-1:0] wr_addr_fused,
  output logic [WE_W-1:0]   we_fused
);

  localparam int BK_W = $clog2(N_W1 + N_W2 + 1);

  typedef enum logic [2:0] {IDLE, LD_IFM, LD_W1, LD_W2, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   off_q, off_d;
  logic [CNT_W-1:0]    wcnt_q, wcnt_d;
  logic [BK_W-1:0]     bank_q, bank_d;
  logic [ADDR_W-1:0]   base_i_q, base_1_q, base_2_q;
  logic [CNT_W-1:0]    size_i_q, size_1_q, size_2_q;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [WE_W-1:0]     we_q, we_d;
  logic                done_q, ready_q;

  logic                accept;
  logic [ADDR_W-1:0]   base_i_e, base_1_e, base_2_e, base_nxt;
  logic [CNT_W-1:0]    size_i_e, size_1_e, size_2_e, size_cur;
  logic [BK_W-1:0]     last_bank;

  // First non-empty phase after s; empty phases cost no cycles.
  function automatic state_t next_phase(input state_t s, input logic [CNT_W-1:0] si,
                                        input logic [CNT_W-1:0] s1, input logic [CNT_W-1:0] s2);
    state_t r;
    r = DRAIN;
    unique case (s)
      IDLE:    r = (si != '0) ? LD_IFM : (s1 != '0) ? LD_W1 : (s2 != '0) ? LD_W2 : DRAIN;
      LD_IFM:  r = (s1 != '0) ? LD_W1 : (s2 != '0) ? LD_W2 : DRAIN;
      LD_W1:   r = (s2 != '0) ? LD_W2 : DRAIN;
      default: r = DRAIN;
    endcase
    return r;
  endfunction

  assign accept = (state_q == IDLE) && start;

  always_comb begin
    // In IDLE the live inputs are used so the first read address is ready at the accepting edge.
    base_i_e = (state_q == IDLE) ? base_addr_IFM            : base_i_q;
    base_1_e = (state_q == IDLE) ? base_addr_Weight_layer_1 : base_1_q;
    base_2_e = (state_q == IDLE) ? base_addr_Weight_layer_2 : base_2_q;
    size_i_e = (state_q == IDLE) ? size_IFM                 : size_i_q;
    size_1_e = (state_q == IDLE) ? size_Weight_layer_1      : size_1_q;
    size_2_e = (state_q == IDLE) ? size_Weight_layer_2      : size_2_q;

    state_d   = state_q;
    off_d     = off_q;
    wcnt_d    = wcnt_q;
    bank_d    = bank_q;
    size_cur  = '0;
    last_bank = '0;
    unique case (state_q)
      LD_IFM: begin size_cur = size_i_e; last_bank = '0;                 end
      LD_W1:  begin size_cur = size_1_e; last_bank = BK_W'(N_W1 - 1);    end
      LD_W2:  begin size_cur = size_2_e; last_bank = BK_W'(N_W2 - 1);    end
      default: ;
    endcase

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = next_phase(IDLE, size_i_e, size_1_e, size_2_e);
          off_d   = '0;
          wcnt_d  = '0;
          bank_d  = '0;
        end
      end
      LD_IFM, LD_W1, LD_W2: begin
        if (wcnt_q == size_cur - 1'b1) begin
          wcnt_d = '0;
          if (bank_q != last_bank) begin
            bank_d = bank_q + 1'b1;
            off_d  = off_q + 1'b1;
          end else begin
            bank_d  = '0;
            off_d   = '0;
            state_d = next_phase(state_q, size_i_e, size_1_e, size_2_e);
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
          off_d  = off_q + 1'b1;
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    base_nxt = '0;
    unique case (state_d)
      LD_IFM:  base_nxt = base_i_e;
      LD_W1:   base_nxt = base_1_e;
      LD_W2:   base_nxt = base_2_e;
      default: base_nxt = '0;
    endcase
    rd_addr_d = (state_d == LD_IFM || state_d == LD_W1 || state_d == LD_W2)
                ? base_nxt + off_d : '0;

    // Write side mirrors the read issued this cycle, landing one cycle later.
    we_d = '0;
    unique case (state_q)
      LD_IFM:  we_d[WE_W-1] = 1'b1;
      LD_W1:   we_d[int'(bank_q)] = 1'b1;
      LD_W2:   we_d[N_W1 + int'(bank_q)] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      off_q     <= '0;
      wcnt_q    <= '0;
      bank_q    <= '0;
      base_i_q  <= '0;
      base_1_q  <= '0;
      base_2_q  <= '0;
      size_i_q  <= '0;
      size_1_q  <= '0;
      size_2_q  <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      we_q      <= '0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      off_q     <= off_d;
      wcnt_q    <= wcnt_d;
      bank_q    <= bank_d;
      if (accept) begin
        base_i_q <= base_addr_IFM;
        base_1_q <= base_addr_Weight_layer_1;
        base_2_q <= base_addr_Weight_layer_2;
        size_i_q <= size_IFM;
        size_1_q <= size_Weight_layer_1;
        size_2_q <= size_Weight_layer_2;
      end
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= ADDR_W'(wcnt_q);
      we_q      <= we_d;
      done_q    <= (state_q == DRAIN);
      ready_q   <= (state_d == IDLE);
    end
  end

  assign ready          = ready_q;
  assign done           = done_q;
  assign rd_addr_global = rd_addr_q;
  assign we_global      = 1'b0;
  assign wr_addr_fused  = wr_addr_q;
  assign we_fused       = we_q;

endmodule

// File: tb/tb_global_fused_load_scheduler.sv
// Directed bench for global_fused_load_scheduler: expected read/write streams
// are built from the tile description and compared edge by edge.
module tb_global_fused_load_scheduler;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        ready, done, we_global;
  logic [31:0] base_addr_IFM, base_addr_Weight_layer_1, base_addr_Weight_layer_2;
  logic [15:0] size_IFM, size_Weight_layer_1, size_Weight_layer_2;
  logic [31:0] rd_addr_global, wr_addr_fused;
  logic [20:0] we_fused;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  global_fused_load_scheduler #(.ADDR_W(32), .CNT_W(16), .N_W1(16), .N_W2(4), .WE_W(21)) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready), .done(done),
    .base_addr_IFM(base_addr_IFM), .size_IFM(size_IFM),
    .base_addr_Weight_layer_1(base_addr_Weight_layer_1), .size_Weight_layer_1(size_Weight_layer_1),
    .base_addr_Weight_layer_2(base_addr_Weight_layer_2), .size_Weight_layer_2(size_Weight_layer_2),
    .rd_addr_global(rd_addr_global), .we_global(we_global),
    .wr_addr_fused(wr_addr_fused), .we_fused(we_fused)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: plain, 1: busy start + base changes in W1, 2: reset at first bank-5 write,
  // 3: start held high so a second load is accepted on the done cycle.
  task automatic load(input logic [31:0] bi, input logic [15:0] si,
                      input logic [31:0] b1, input logic [15:0] s1,
                      input logic [31:0] b2, input logic [15:0] s2, input int mode);
    int unsigned exp_rd[$];
    int unsigned exp_we[$];
    int unsigned exp_wa[$];
    int unsigned n;
    int unsigned k;
    logic [20:0] onehot;
    for (int unsigned w = 0; w < si; w++) begin
      exp_rd.push_back(bi + w); exp_we.push_back(20); exp_wa.push_back(w);
    end
    for (int unsigned b = 0; b < 16; b++)
      for (int unsigned w = 0; w < s1; w++) begin
        exp_rd.push_back(b1 + b * s1 + w); exp_we.push_back(b); exp_wa.push_back(w);
      end
    for (int unsigned b = 0; b < 4; b++)
      for (int unsigned w = 0; w < s2; w++) begin
        exp_rd.push_back(b2 + b * s2 + w); exp_we.push_back(16 + b); exp_wa.push_back(w);
      end
    n = exp_rd.size();

    @(negedge clk);
    base_addr_IFM = bi; size_IFM = si;
    base_addr_Weight_layer_1 = b1; size_Weight_layer_1 = s1;
    base_addr_Weight_layer_2 = b2; size_Weight_layer_2 = s2;
    start = 1'b1;
    tick();
    chk("accept_ready", ready, 1'b0);
    if (mode != 3) start = 1'b0;

    for (int unsigned e = 1; e <= n + 1; e++) begin
      if (e > 1) tick();
      if (e <= n) chk("rd_addr", rd_addr_global, exp_rd[e-1]);
      if (e >= 2) begin
        onehot = '0;
        onehot[exp_we[e-2]] = 1'b1;
        chk("we_fused", we_fused, onehot);
        chk("wr_addr", wr_addr_fused, exp_wa[e-2]);
      end else begin
        chk("we_idle", we_fused, 21'd0);
      end
      chk("done_low", done, 1'b0);
      chk("we_global", we_global, 1'b0);
      if (mode == 1 && e == si + 5) begin
        start = 1'b1;
        base_addr_IFM = 32'hDEAD_0000;
        base_addr_Weight_layer_1 = 32'hBEEF_0000;
        base_addr_Weight_layer_2 = 32'hCAFE_0000;
        size_Weight_layer_2 = 16'd7;
      end
      if (mode == 1 && e == si + 6) start = 1'b0;
      if (mode == 2 && e >= 2 && exp_we[e-2] == 5) begin
        reset = 1'b1;
        tick();
        chk("rst_we", we_fused, 21'd0);
        chk("rst_ready", ready, 1'b1);
        chk("rst_done", done, 1'b0);
        reset = 1'b0;
        return;
      end
    end

    tick();
    chk("done_pulse", done, 1'b1);
    chk("done_ready", ready, 1'b1);
    chk("done_we", we_fused, 21'd0);

    if (mode == 3) begin
      tick();
      chk("b2b_done_clr", done, 1'b0);
      chk("b2b_ready", ready, 1'b0);
      chk("b2b_rd", rd_addr_global, bi);
      start = 1'b0;
      k = 0;
      for (int unsigned c = 1; c <= 200 && k == 0; c++) begin
        tick();
        if (done) k = c;
      end
      chk("b2b_latency", k, n + 1);
    end else begin
      tick();
      chk("done_once", done, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    base_addr_IFM = '0; size_IFM = '0;
    base_addr_Weight_layer_1 = '0; size_Weight_layer_1 = '0;
    base_addr_Weight_layer_2 = '0; size_Weight_layer_2 = '0;
    tick();
    tick();
    chk("rst_ready0", ready, 1'b1);
    chk("rst_done0", done, 1'b0);
    chk("rst_rd0", rd_addr_global, 32'd0);
    chk("rst_wa0", wr_addr_fused, 32'd0);
    chk("rst_we0", we_fused, 21'd0);
    @(negedge clk);
    reset = 1'b0;

    // basic load
    load(32'h10, 16'd3, 32'h100, 16'd2, 32'h200, 16'd1, 0);
    // all sizes zero
    load(32'h40, 16'd0, 32'h50, 16'd0, 32'h60, 16'd0, 0);
    // layer-1 skipped
    load(32'h20, 16'd1, 32'h300, 16'd0, 32'h400, 16'd1, 0);
    // busy start and base changes ignored
    load(32'h10, 16'd3, 32'h100, 16'd2, 32'h200, 16'd1, 1);
    // reset mid layer-1, then a fresh identical load
    load(32'h10, 16'd3, 32'h100, 16'd2, 32'h200, 16'd1, 2);
    load(32'h10, 16'd3, 32'h100, 16'd2, 32'h200, 16'd1, 0);
    // back-to-back via start held across done
    load(32'h70, 16'd2, 32'h800, 16'd1, 32'h900, 16'd2, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
